// File: rtl/fp_pkg.sv
// Shared widths, GRS bit positions, FSM states and result structs
// for the single-precision normalize/round stage.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MAN_W  = 27;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    // Bit positions inside the 27-bit mantissa (1.23 + G/R/S)
    localparam int L_BIT = 3;
    localparam int G_BIT = 2;
    localparam int R_BIT = 1;
    localparam int S_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } norm_state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalized 27-bit mantissa and pack to binary32.
// Latency: combinational.
// Backpressure: none; the caller registers the outputs.
module fp_round_rne
    import fp_pkg::*;
(
    input  logic [MAN_W-1:0] man,
    input  logic [EXP_W:0]   exponent,
    input  logic             sign,
    output fp32_t            result,
    output fp_flags_t        flags
);

    logic              lsb, grd, rnd, stk, up;
    logic [FRAC_W+1:0] m_sum;
    logic [FRAC_W:0]   m_norm;
    logic [EXP_W:0]    exp_adj;
    logic [EXP_W-1:0]  field;
    logic              ovf, inx;

    assign lsb = man[L_BIT];
    assign grd = man[G_BIT];
    assign rnd = man[R_BIT];
    assign stk = man[S_BIT];
    assign up  = grd & (lsb | rnd | stk);

    assign m_sum = {1'b0, man[MAN_W-1:L_BIT]} + {{(FRAC_W+1){1'b0}}, up};

    always_comb begin
        m_norm  = m_sum[FRAC_W:0];
        exp_adj = exponent;
        // Rounding carried into a new integer bit: renormalize by one
        if (m_sum[FRAC_W+1]) begin
            m_norm  = m_sum[FRAC_W+1:1];
            exp_adj = exponent + (EXP_W+1)'(1);
        end

        inx   = grd | rnd | stk;
        ovf   = (exp_adj >= {1'b0, EXP_MAX});
        field = m_norm[FRAC_W] ? exp_adj[EXP_W-1:0] : '0;

        result.sign = sign;
        result.exp  = field;
        result.frac = m_norm[FRAC_W-1:0];
        if (ovf) begin
            result.exp  = EXP_MAX;
            result.frac = '0;
        end

        flags.overflow  = ovf;
        flags.inexact   = inx | ovf;
        flags.underflow = (result.exp == '0) & inx;
    end

endmodule

// File: rtl/fp_normalize_round.sv
// Post-ALU normalize (one bit per cycle), round-to-nearest-even and binary32 pack.
// Latency: out_valid at accept edge + n + 2, n = left shifts (0..26).
// Backpressure: single op in flight; DONE holds outputs until out_ready, in_ready only in IDLE.
module fp_normalize_round
    import fp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAN_W-1:0] in_mantissa,
    input  logic             in_carry,
    input  logic [EXP_W-1:0] in_exponent,
    input  logic             in_sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_overflow,
    output logic             out_underflow,
    output logic             out_inexact
);

    norm_state_t      state_q, state_d;
    logic [MAN_W:0]   man_q;
    logic [EXP_W:0]   exp_q;
    logic             sign_q;
    fp32_t            res_q;
    fp_flags_t        flags_q;

    fp32_t            rnd_result;
    fp_flags_t        rnd_flags;

    logic             norm_carry;
    logic             norm_stop;

    assign norm_carry = man_q[MAN_W];
    assign norm_stop  = norm_carry
                      | (man_q == '0)
                      | man_q[MAN_W-1]
                      | (exp_q == (EXP_W+1)'(1));

    fp_round_rne u_round (
        .man      (man_q[MAN_W-1:0]),
        .exponent (exp_q),
        .sign     (sign_q),
        .result   (rnd_result),
        .flags    (rnd_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (in_valid)  state_d = ST_NORM;
            ST_NORM:  if (norm_stop) state_d = ST_ROUND;
            ST_ROUND: state_d = ST_DONE;
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            man_q   <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        man_q  <= {in_carry, in_mantissa};
                        // Exponent 0 behaves as 1 so subnormals never shift
                        exp_q  <= (in_exponent == '0) ? (EXP_W+1)'(1)
                                                      : {1'b0, in_exponent};
                        sign_q <= in_sign;
                    end
                end
                ST_NORM: begin
                    if (norm_carry) begin
                        // Right shift folds the two dropped bits into sticky
                        man_q <= {1'b0, man_q[MAN_W:2], man_q[1] | man_q[0]};
                        exp_q <= exp_q + (EXP_W+1)'(1);
                    end else if (!norm_stop) begin
                        man_q <= {man_q[MAN_W-1:0], 1'b0};
                        exp_q <= exp_q - (EXP_W+1)'(1);
                    end
                end
                ST_ROUND: begin
                    res_q   <= rnd_result;
                    flags_q <= rnd_flags;
                end
                default: ;
            endcase
        end
    end

    assign out_result    = res_q;
    assign out_overflow  = flags_q.overflow;
    assign out_underflow = flags_q.underflow;
    assign out_inexact   = flags_q.inexact;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Randomized and directed check of fp_normalize_round against an arithmetic
// model of normalization, RNE rounding, latency and handshake behaviour.
module tb_fp_normalize_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [26:0] in_mantissa;
    logic        in_carry;
    logic [7:0]  in_exponent;
    logic        in_sign;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow, out_underflow, out_inexact;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [2:0]  flg;   // {overflow, underflow, inexact}
        logic [7:0]  lat;
    } model_t;

    fp_normalize_round dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_mantissa   (in_mantissa),
        .in_carry      (in_carry),
        .in_exponent   (in_exponent),
        .in_sign       (in_sign),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_inexact   (out_inexact)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Value-level model: count leading zeros limited by the exponent floor,
    // then round the low three bits as a remainder out of eight.
    function automatic model_t ref_model(input logic c, input logic [26:0] m,
                                         input logic [7:0] e_in, input logic s);
        longint sig, keep, rem;
        int     e, fexp;
        model_t r;
        sig = 0;
        sig[27:0] = {c, m};
        e = (e_in == 0) ? 1 : int'(e_in);
        r.lat = 8'd2;
        if (sig >= (64'sd1 <<< 27)) begin
            sig = ((sig >>> 2) <<< 1) | (((sig & 3) != 0) ? 64'sd1 : 64'sd0);
            e++;
        end else if (sig != 0) begin
            while (sig < (64'sd1 <<< 26) && e > 1) begin
                sig = sig * 2;
                e--;
                r.lat++;
            end
        end
        keep = sig >>> 3;
        rem  = sig & 7;
        if (rem > 4 || (rem == 4 && (keep % 2) == 1)) keep++;
        if (keep >= (64'sd1 <<< 24)) begin
            keep = keep >>> 1;
            e++;
        end
        fexp = (keep >= (64'sd1 <<< 23)) ? e : 0;
        if (e >= 255) begin
            r.res = {s, 8'hFF, 23'h0};
            r.flg = 3'b101;
        end else begin
            r.res = {s, 8'(fexp), keep[22:0]};
            r.flg = {1'b0, (fexp == 0) && (rem != 0), rem != 0};
        end
        return r;
    endfunction

    task automatic run_op(input logic c, input logic [26:0] m, input logic [7:0] e,
                          input logic s, input int hold);
        model_t want;
        int     cyc;
        want = ref_model(c, m, e, s);
        @(negedge clk);
        check_eq("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_carry = c; in_mantissa = m; in_exponent = e; in_sign = s;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("latency", 64'(cyc), 64'(want.lat));
        if (!out_valid) begin
            rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
            return;
        end
        check_eq("result", 64'(out_result), 64'(want.res));
        check_eq("flags", 64'({out_overflow, out_underflow, out_inexact}), 64'(want.flg));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq("hold_result", 64'(out_result), 64'(want.res));
            check_eq("hold_flags", 64'({out_overflow, out_underflow, out_inexact}), 64'(want.flg));
            check_eq("hold_valid", 64'(out_valid), 64'd1);
            check_eq("hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        check_eq("post_valid", 64'(out_valid), 64'd0);
        check_eq("post_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [26:0] rm;
        logic [7:0]  re;
        rst = 1'b1; in_valid = 1'b0; in_mantissa = '0; in_carry = 1'b0;
        in_exponent = '0; in_sign = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_result", 64'(out_result), 64'd0);
        check_eq("rst_flags", 64'({out_overflow, out_underflow, out_inexact}), 64'd0);
        rst = 1'b0;

        // Plain value checks against hand-derived words
        run_op(1'b1, 27'h0, 8'd127, 1'b0, 0);
        check_eq("carry_word", 64'(out_result), 64'h40000000);
        run_op(1'b0, 27'h0000008, 8'd127, 1'b0, 0);
        check_eq("cancel_word", 64'(out_result), 64'h34000000);
        run_op(1'b0, 27'h400000C, 8'd127, 1'b0, 0);
        check_eq("tie_odd_word", 64'(out_result), 64'h3F800002);
        run_op(1'b0, 27'h4000004, 8'd127, 1'b0, 0);
        check_eq("tie_even_word", 64'(out_result), 64'h3F800000);
        run_op(1'b0, 27'h7FFFFFC, 8'd127, 1'b0, 0);
        check_eq("round_carry_word", 64'(out_result), 64'h40000000);
        run_op(1'b1, 27'h0, 8'd254, 1'b0, 0);
        check_eq("overflow_word", 64'(out_result), 64'h7F800000);
        check_eq("overflow_flag", 64'(out_overflow), 64'd1);
        run_op(1'b0, 27'h0000010, 8'd1, 1'b0, 0);
        check_eq("subnormal_word", 64'(out_result), 64'h00000002);
        run_op(1'b0, 27'h0, 8'd100, 1'b1, 0);
        check_eq("neg_zero_word", 64'(out_result), 64'h80000000);
        run_op(1'b0, 27'h0000123, 8'd0, 1'b0, 0);
        run_op(1'b0, 27'h0000001, 8'd127, 1'b1, 0);

        // Backpressure: five stalled cycles in DONE
        run_op(1'b0, 27'h5A5A5A7, 8'd200, 1'b1, 5);

        // Reset in the middle of a long normalization
        @(negedge clk);
        in_valid = 1'b1; in_carry = 1'b0; in_mantissa = 27'h0000008;
        in_exponent = 8'd127; in_sign = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
        check_eq("midrst_result", 64'(out_result), 64'd0);
        repeat (30) @(posedge clk);
        #1;
        check_eq("midrst_no_output", 64'(out_valid), 64'd0);
        run_op(1'b0, 27'h400000C, 8'd127, 1'b0, 0);

        // Randomized operands spread over shift counts and exponent ranges
        for (int k = 0; k < 150; k++) begin
            rm = 27'($urandom());
            rm = rm >> $urandom_range(0, 26);
            if ($urandom_range(0, 15) == 0) rm = '0;
            re = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 30))
                                             : 8'($urandom_range(0, 254));
            run_op($urandom_range(0, 3) == 0, rm, re, 1'($urandom()), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
